// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, imem req/ready handshake, and the IF/ID pipeline
// register, with hazard freeze (skid buffer) and branch redirect (wrong-path squash).
module if_stage_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        Br_Taken,
   input  logic [31:0] Br_Offset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] Instruction,
   output logic        Valid
);

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc_q, pc_q_n;
   logic [31:0] pc_r, pc_r_n;
   logic [31:0] skid, skid_n;
   logic [31:0] id_pc_n, id_ins_n;
   logic        id_vld_n;

   logic        br;
   logic [31:0] target;
   logic [31:0] pc_inc;

   // A branch seen while frozen is ignored; decode presents it again once the stall clears.
   assign br     = Br_Taken & ~freeze & Valid;
   assign target = PC + (Br_Offset << 2);
   assign pc_inc = pc_q + 32'd4;

   assign imem_addr = pc_q;
   assign imem_req  = (state != HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= REQ;
         pc_q        <= RESET_PC;
         pc_r        <= '0;
         skid        <= '0;
         PC          <= '0;
         Instruction <= '0;
         Valid       <= 1'b0;
      end else begin
         state       <= state_n;
         pc_q        <= pc_q_n;
         pc_r        <= pc_r_n;
         skid        <= skid_n;
         PC          <= id_pc_n;
         Instruction <= id_ins_n;
         Valid       <= id_vld_n;
      end
   end

   always_comb begin
      state_n  = state;
      pc_q_n   = pc_q;
      pc_r_n   = pc_r;
      skid_n   = skid;
      id_pc_n  = PC;
      id_ins_n = Instruction;
      id_vld_n = Valid;

      unique case (state)
         REQ: begin
            if (br) begin
               id_pc_n  = '0;
               id_ins_n = '0;
               id_vld_n = 1'b0;
               if (imem_ready) begin
                  pc_q_n = target;
               end else begin
                  // Request already on the bus must complete before the address may move.
                  pc_r_n  = target;
                  state_n = DRAIN;
               end
            end else if (imem_ready) begin
               if (!freeze) begin
                  id_pc_n  = pc_inc;
                  id_ins_n = imem_rdata;
                  id_vld_n = 1'b1;
                  pc_q_n   = pc_inc;
               end else begin
                  skid_n  = imem_rdata;
                  state_n = HOLD;
               end
            end
         end

         HOLD: begin
            if (br) begin
               id_pc_n  = '0;
               id_ins_n = '0;
               id_vld_n = 1'b0;
               pc_q_n   = target;
               state_n  = REQ;
            end else if (!freeze) begin
               id_pc_n  = pc_inc;
               id_ins_n = skid;
               id_vld_n = 1'b1;
               pc_q_n   = pc_inc;
               state_n  = REQ;
            end
         end

         DRAIN: begin
            if (imem_ready) begin
               pc_q_n  = pc_r;
               state_n = REQ;
            end
         end

         default: begin
            state_n = REQ;
         end
      endcase
   end

   a_addr_stable : assert property (@(posedge clk) disable iff (rst)
      (imem_req && !imem_ready) |=> $stable(imem_addr));

   a_bubble_zero : assert property (@(posedge clk) disable iff (rst)
      !Valid |-> (Instruction == 32'h0));

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch: directed cycle steps with expected IF/ID and
// fetch-port values queued at drive time and compared one cycle later.
module tb_if_stage_fetch;

   localparam logic [31:0] B = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        Br_Taken;
   logic [31:0] Br_Offset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        Valid;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        vld;
      logic [31:0] addr;
      logic        req;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_n = 0;

   if_stage_fetch #(.RESET_PC(B)) dut (
      .clk         (clk),
      .rst         (rst),
      .freeze      (freeze),
      .Br_Taken    (Br_Taken),
      .Br_Offset   (Br_Offset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .PC          (PC),
      .Instruction (Instruction),
      .Valid       (Valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Memory returns an address-tagged word for whatever is on the bus.
   always_comb imem_rdata = word(imem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic compare_head();
      exp_t e;
      e = exp_q.pop_front();
      if (!$isunknown(e.pc)) check($sformatf("s%0d PC", step_n), PC, e.pc);
      check($sformatf("s%0d Instruction", step_n), Instruction, e.ins);
      check($sformatf("s%0d Valid", step_n), {31'b0, Valid}, {31'b0, e.vld});
      check($sformatf("s%0d imem_addr", step_n), imem_addr, e.addr);
      check($sformatf("s%0d imem_req", step_n), {31'b0, imem_req}, {31'b0, e.req});
   endtask

   // Drive one cycle of inputs, queue what the stage must show after the next edge, compare.
   task automatic step(input logic fr, input logic bt, input logic [31:0] off, input logic rdy,
                       input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_vld,
                       input logic [31:0] e_addr, input logic e_req);
      exp_t e;
      freeze     = fr;
      Br_Taken   = bt;
      Br_Offset  = off;
      imem_ready = rdy;
      e.pc = e_pc; e.ins = e_ins; e.vld = e_vld; e.addr = e_addr; e.req = e_req;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      step_n++;
      compare_head();
   endtask

   initial begin
      exp_t        e;
      logic [31:0] xx;
      logic [31:0] far_off;
      xx = 'x;

      rst = 1'b1; freeze = 1'b0; Br_Taken = 1'b0; Br_Offset = '0; imem_ready = 1'b0;
      @(posedge clk);
      #1;
      e.pc = 32'h0; e.ins = 32'h0; e.vld = 1'b0; e.addr = B; e.req = 1'b1;
      exp_q.push_back(e);
      compare_head();
      rst = 1'b0;

      // back-to-back fetch
      step(0, 0, 0, 1, B + 32'h04, word(B),          1, B + 32'h04, 1);
      step(0, 0, 0, 1, B + 32'h08, word(B + 32'h04), 1, B + 32'h08, 1);
      // memory wait at addr 8
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 0, B + 32'h08, word(B + 32'h04), 1, B + 32'h08, 1);
      step(0, 0, 0, 1, B + 32'h0C, word(B + 32'h08), 1, B + 32'h0C, 1);
      // freeze while word@C returns -> parked in skid, req dropped
      step(1, 0, 0, 1, B + 32'h0C, word(B + 32'h08), 1, B + 32'h0C, 0);
      step(1, 0, 0, 0, B + 32'h0C, word(B + 32'h08), 1, B + 32'h0C, 0);
      step(0, 0, 0, 0, B + 32'h10, word(B + 32'h0C), 1, B + 32'h10, 1);
      step(0, 0, 0, 1, B + 32'h14, word(B + 32'h10), 1, B + 32'h14, 1);
      step(0, 0, 0, 1, B + 32'h18, word(B + 32'h14), 1, B + 32'h18, 1);
      step(0, 0, 0, 1, B + 32'h1C, word(B + 32'h18), 1, B + 32'h1C, 1);
      step(0, 0, 0, 1, B + 32'h20, word(B + 32'h1C), 1, B + 32'h20, 1);
      // taken branch, offset -2 words, memory ready
      step(0, 1, -32'sd2, 1, xx, 32'h0, 0, B + 32'h18, 1);
      step(0, 0, 0, 1, B + 32'h1C, word(B + 32'h18), 1, B + 32'h1C, 1);
      // taken branch while request pending -> drain stale word
      step(0, 1, 32'd4, 0, xx, 32'h0, 0, B + 32'h1C, 1);
      step(0, 1, 32'd4, 0, xx, 32'h0, 0, B + 32'h1C, 1);
      step(0, 0, 0, 1, xx, 32'h0, 0, B + 32'h2C, 1);
      step(0, 0, 0, 1, B + 32'h30, word(B + 32'h2C), 1, B + 32'h30, 1);
      // branch ignored while frozen
      step(1, 1, -32'sd8, 0, B + 32'h30, word(B + 32'h2C), 1, B + 32'h30, 1);
      step(1, 1, -32'sd8, 1, B + 32'h30, word(B + 32'h2C), 1, B + 32'h30, 0);
      // freeze drops with branch still presented -> skid discarded, redirect
      step(0, 1, -32'sd8, 0, xx, 32'h0, 0, B + 32'h10, 1);
      step(0, 0, 0, 1, B + 32'h14, word(B + 32'h10), 1, B + 32'h14, 1);
      // enter DRAIN, then reset mid-transaction
      step(0, 1, 32'd1, 0, xx, 32'h0, 0, B + 32'h14, 1);
      Br_Taken = 1'b0; imem_ready = 1'b0;
      rst = 1'b1;
      #1;
      e.pc = 32'h0; e.ins = 32'h0; e.vld = 1'b0; e.addr = B; e.req = 1'b1;
      exp_q.push_back(e);
      compare_head();
      @(posedge clk);
      #1;
      rst = 1'b0;
      // restart from RESET_PC, then branch to the top of the address space and wrap
      step(0, 0, 0, 1, B + 32'h04, word(B), 1, B + 32'h04, 1);
      far_off = (32'hFFFF_FFFC - (B + 32'h04)) >> 2;
      step(0, 1, far_off, 1, xx, 32'h0, 0, 32'hFFFF_FFFC, 1);
      step(0, 0, 0, 1, 32'h0000_0000, word(32'hFFFF_FFFC), 1, 32'h0000_0000, 1);
      step(0, 0, 0, 1, 32'h0000_0004, word(32'h0000_0000), 1, 32'h0000_0004, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
